// File: rtl/vec_add_tg_pkg.sv
// Shared types and constants for the vector-adder traffic generator.
package vec_add_tg_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    // Galois feedback mask used by both operand LFSRs.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Constant vector for fixed mode, lane 0 first.
    localparam int FIX_A [LANES] = '{0, 3, 2, 1};
    localparam int FIX_B [LANES] = '{-2, 2, 4, 8};

    typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_DRIVE,
        ST_DRAIN,
        ST_DONE
    } tg_state_t;

    // One right-shifting Galois step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/vec_add_traffic_gen_lfsr.sv
// 32-bit Galois LFSR; reloads its seed on reset (a zero seed becomes 1).
module tg_lfsr32
    import vec_add_tg_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_seed,
    input  logic        i_advance,
    output logic [31:0] o_value
);

    logic [31:0] r_value;

    // Seed reload on reset, otherwise step only when asked.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_value <= (i_seed == 32'h0) ? 32'h1 : i_seed;
        end else if (i_advance) begin
            r_value <= lfsr_step(r_value);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/vec_add_traffic_gen.sv
// Drives a 4-lane pipelined vector adder and checks its results.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | waiting for start
// ST_WARMUP | idle delay covering downstream init, en=0
// ST_DRIVE  | one new operand vector per cycle, en=1
// ST_DRAIN  | en=1 with zero operands so the last results emerge
// ST_DONE   | counts final, done=1, held until reset
module vec_add_traffic_gen
    import vec_add_tg_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int          LATENCY  = 2,
    parameter int          NUM_VECS = 16,
    parameter int          WARMUP   = 4995,
    parameter logic [31:0] SEED_A   = 32'h1,
    parameter logic [31:0] SEED_B   = 32'h2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_fixed_mode,
    output logic [WIDTH-1:0] o_a_0,
    output logic [WIDTH-1:0] o_a_1,
    output logic [WIDTH-1:0] o_a_2,
    output logic [WIDTH-1:0] o_a_3,
    output logic [WIDTH-1:0] o_b_0,
    output logic [WIDTH-1:0] o_b_1,
    output logic [WIDTH-1:0] o_b_2,
    output logic [WIDTH-1:0] o_b_3,
    output logic             o_en,
    input  logic [WIDTH-1:0] i_y_0,
    input  logic [WIDTH-1:0] i_y_1,
    input  logic [WIDTH-1:0] i_y_2,
    input  logic [WIDTH-1:0] i_y_3,
    output logic             o_done,
    output logic             o_pass,
    output logic [15:0]      o_err_count,
    output logic [15:0]      o_vec_count
);

    typedef logic [LANES-1:0][WIDTH-1:0] lane_vec_t;

    tg_state_t   r_state, w_state_nxt;
    logic [31:0] r_cnt;
    logic        r_fixed;
    logic        r_en;
    lane_vec_t   r_a, r_b;
    lane_vec_t   w_next_a, w_next_b, w_sum, w_y;
    logic [31:0] w_lfsr_a, w_lfsr_b;
    logic        w_advance;
    logic        w_mismatch;
    logic [LATENCY-1:0] r_pipe_vld;
    lane_vec_t   r_pipe_exp [LATENCY];
    logic [15:0] r_err, r_vec;

    assign w_advance = (w_state_nxt == ST_DRIVE);
    assign w_y       = {i_y_3, i_y_2, i_y_1, i_y_0};

    tg_lfsr32 u_lfsr_a (
        .clock     (clock),
        .reset     (reset),
        .i_seed    (SEED_A),
        .i_advance (w_advance),
        .o_value   (w_lfsr_a)
    );

    tg_lfsr32 u_lfsr_b (
        .clock     (clock),
        .reset     (reset),
        .i_seed    (SEED_B),
        .i_advance (w_advance),
        .o_value   (w_lfsr_b)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; each timed state exits when its down-counter hits 0.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (i_start)        w_state_nxt = ST_WARMUP;
            ST_WARMUP: if (r_cnt == 32'h0) w_state_nxt = ST_DRIVE;
            ST_DRIVE:  if (r_cnt == 32'h0) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (r_cnt == 32'h0) w_state_nxt = ST_DONE;
            default:                       w_state_nxt = r_state;
        endcase
    end

    // Shared down-counter, reloaded on each state entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= 32'h0;
        end else if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                ST_WARMUP: r_cnt <= 32'(WARMUP);
                ST_DRIVE:  r_cnt <= 32'(NUM_VECS - 1);
                ST_DRAIN:  r_cnt <= 32'(LATENCY - 1);
                default:   r_cnt <= 32'h0;
            endcase
        end else if (r_cnt != 32'h0) begin
            r_cnt <= r_cnt - 32'h1;
        end
    end

    // Capture the mode as the run leaves IDLE.
    always_ff @(posedge clock) begin
        if (!reset)                            r_fixed <= 1'b0;
        else if (r_state == ST_IDLE && i_start) r_fixed <= i_fixed_mode;
    end

    // Candidate operand vector and the wrapped sum of the presented one.
    always_comb begin
        w_next_a = '0;
        w_next_b = '0;
        w_sum    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_fixed) begin
                w_next_a[i] = WIDTH'(FIX_A[i]);
                w_next_b[i] = WIDTH'(FIX_B[i]);
            end else begin
                w_next_a[i] = w_lfsr_a[WIDTH*i +: WIDTH];
                w_next_b[i] = w_lfsr_b[WIDTH*i +: WIDTH];
            end
            w_sum[i] = r_a[i] + r_b[i];
        end
    end

    // Registered operands and enable, set up for the cycle being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_a  <= '0;
            r_b  <= '0;
            r_en <= 1'b0;
        end else begin
            r_en <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_DRAIN);
            if (w_state_nxt == ST_DRIVE) begin
                r_a <= w_next_a;
                r_b <= w_next_b;
            end else begin
                r_a <= '0;
                r_b <= '0;
            end
        end
    end

    // Expected-result pipe, advancing in lockstep with the DUT's enable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pipe_vld <= '0;
        end else if (r_en) begin
            r_pipe_vld[0] <= (r_state == ST_DRIVE);
            r_pipe_exp[0] <= w_sum;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_exp[i] <= r_pipe_exp[i-1];
            end
        end
    end

    assign w_mismatch = (r_pipe_exp[LATENCY-1] != w_y);

    // Per-vector accounting at the pipe tail; error count saturates.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err <= 16'h0;
            r_vec <= 16'h0;
        end else if (r_en && r_pipe_vld[LATENCY-1]) begin
            r_vec <= r_vec + 16'h1;
            if (w_mismatch && r_err != 16'hFFFF) r_err <= r_err + 16'h1;
        end
    end

    assign o_a_0       = r_a[0];
    assign o_a_1       = r_a[1];
    assign o_a_2       = r_a[2];
    assign o_a_3       = r_a[3];
    assign o_b_0       = r_b[0];
    assign o_b_1       = r_b[1];
    assign o_b_2       = r_b[2];
    assign o_b_3       = r_b[3];
    assign o_en        = r_en;
    assign o_done      = (r_state == ST_DONE);
    assign o_pass      = (r_state == ST_DONE) && (r_err == 16'h0);
    assign o_err_count = r_err;
    assign o_vec_count = r_vec;

endmodule

// File: tb/tb_vec_add_traffic_gen.sv
// Bench for vec_add_traffic_gen: two instances, a behavioural adder with
// selectable depth and fault, an operand scoreboard and end-of-run checks.
module tb_vec_add_traffic_gen;

    localparam int          NV_T [2] = '{4, 16};
    localparam int          WU_T [2] = '{10, 0};
    localparam logic [31:0] SA_T [2] = '{32'h8080_8080, 32'h1};
    localparam logic [31:0] SB_T [2] = '{32'h8080_8080, 32'h2};

    logic       clock = 1'b0;
    logic       reset;
    logic       start [2];
    logic       fixed_mode;
    logic [7:0] a [2][4];
    logic [7:0] b [2][4];
    logic [7:0] y [2][4];
    logic       en [2];
    logic       done [2];
    logic       pass [2];
    logic [15:0] err_count [2];
    logic [15:0] vec_count [2];

    int adder_stages [2];
    int fault_idx [2];
    logic [63:0] exp_q [$];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        vec_add_traffic_gen #(
            .WIDTH(8), .LATENCY(2), .NUM_VECS(NV_T[g]), .WARMUP(WU_T[g]),
            .SEED_A(SA_T[g]), .SEED_B(SB_T[g])
        ) u_dut (
            .clock(clock), .reset(reset), .i_start(start[g]), .i_fixed_mode(fixed_mode),
            .o_a_0(a[g][0]), .o_a_1(a[g][1]), .o_a_2(a[g][2]), .o_a_3(a[g][3]),
            .o_b_0(b[g][0]), .o_b_1(b[g][1]), .o_b_2(b[g][2]), .o_b_3(b[g][3]),
            .o_en(en[g]),
            .i_y_0(y[g][0]), .i_y_1(y[g][1]), .i_y_2(y[g][2]), .i_y_3(y[g][3]),
            .o_done(done[g]), .o_pass(pass[g]),
            .o_err_count(err_count[g]), .o_vec_count(vec_count[g])
        );

        logic [7:0] s0 [4];
        logic [7:0] s1 [4];
        logic [7:0] s2 [4];
        int vc;

        // Enable-gated adder with 2 or 3 register stages and an optional lane-2 fault.
        always @(posedge clock) begin
            if (!reset) begin
                for (int l = 0; l < 4; l++) begin
                    s0[l] <= 8'h0; s1[l] <= 8'h0; s2[l] <= 8'h0;
                end
                vc <= 0;
            end else if (en[g]) begin
                for (int l = 0; l < 4; l++) begin
                    s0[l] <= a[g][l] + b[g][l] + ((vc == fault_idx[g] && l == 2) ? 8'd1 : 8'd0);
                    s1[l] <= s0[l];
                    s2[l] <= s1[l];
                end
                vc <= vc + 1;
            end
        end

        for (genvar l = 0; l < 4; l++) begin : g_lane
            assign y[g][l] = (adder_stages[g] == 3) ? s2[l] : s1[l];
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] lfsr_nxt(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [98:0] outs(input int g);
        return {a[g][3], a[g][2], a[g][1], a[g][0], b[g][3], b[g][2], b[g][1], b[g][0],
                en[g], done[g], pass[g], err_count[g], vec_count[g]};
    endfunction

    // Scoreboard monitor: every enabled cycle is either an expected vector or a zero drain cycle.
    task automatic monitor(input int g);
        int idx = 0;
        forever begin
            @(negedge clock);
            if (!en[g]) begin
                idx = 0;
            end else begin
                if (idx < NV_T[g]) begin
                    if (idx >= exp_q.size()) begin
                        n_chk++;
                        $display("FAIL operands inst%0d vec%0d: got en=1 expected no vector", g, idx);
                    end else begin
                        chk($sformatf("operands inst%0d vec%0d", g, idx),
                            {a[g][3], a[g][2], a[g][1], a[g][0], b[g][3], b[g][2], b[g][1], b[g][0]},
                            exp_q[idx]);
                    end
                end else begin
                    chk($sformatf("drain_operands inst%0d", g),
                        {a[g][3], a[g][2], a[g][1], a[g][0], b[g][3], b[g][2], b[g][1], b[g][0]}, 0);
                end
                idx++;
            end
        end
    endtask

    task automatic run(input int g, input bit fx, input int stg, input int fidx,
                       input bit do_rst, input bit abort);
        logic [31:0] va, vb, av, bv, sum, ydut, prev, seen;
        int nv, wu, n, exp_err;
        nv = NV_T[g];
        wu = WU_T[g];
        adder_stages[g] = stg;
        fault_idx[g]    = fidx;
        if (do_rst) begin
            reset = 1'b0;
            repeat (2) @(posedge clock);
            #1 reset = 1'b1;
            @(negedge clock);
            chk($sformatf("reset_outputs inst%0d", g), outs(g), 0);
        end
        exp_q.delete();
        va = (SA_T[g] == 0) ? 32'h1 : SA_T[g];
        vb = (SB_T[g] == 0) ? 32'h1 : SB_T[g];
        prev = 32'h0;
        exp_err = 0;
        for (int k = 0; k < nv; k++) begin
            av = fx ? 32'h0102_0300 : va;
            bv = fx ? 32'h0804_02FE : vb;
            exp_q.push_back({av, bv});
            for (int l = 0; l < 4; l++) sum[8*l +: 8] = av[8*l +: 8] + bv[8*l +: 8];
            ydut = sum;
            if (k == fidx) ydut[23:16] = ydut[23:16] + 8'd1;
            seen = (stg == 3) ? prev : ydut;
            if (seen != sum) exp_err++;
            prev = ydut;
            va = lfsr_nxt(va);
            vb = lfsr_nxt(vb);
        end
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1 start[g] = 1'b1;
        fixed_mode = fx;
        @(posedge clock);
        #1 fixed_mode = ~fx;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (abort && n == wu + 4) begin
                reset = 1'b0;
                start[g] = 1'b0;
                @(posedge clock);
                #1 reset = 1'b1;
                @(negedge clock);
                chk($sformatf("abort_outputs_zero inst%0d", g), outs(g), 0);
                return;
            end
        end while (!done[g] && n < 400);
        chk($sformatf("done_cycle inst%0d", g), n, wu + nv + 4);
        chk($sformatf("vec_count inst%0d", g), vec_count[g], nv);
        chk($sformatf("err_count inst%0d", g), err_count[g], exp_err);
        chk($sformatf("pass inst%0d", g), pass[g], exp_err == 0);
        repeat (6) @(negedge clock);
        chk($sformatf("done_hold inst%0d", g), {done[g], en[g], vec_count[g]}, {1'b1, 1'b0, 16'(nv)});
        @(posedge clock);
        #1 start[g] = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        fixed_mode = 1'b0;
        adder_stages[0] = 2; adder_stages[1] = 2;
        fault_idx[0] = -1;   fault_idx[1] = -1;
        fork
            monitor(0);
            monitor(1);
        join_none
        repeat (3) @(posedge clock);
        run(0, 1'b1, 2, -1, 1'b1, 1'b0);                      // fixed, ideal, WARMUP=10
        run(0, 1'b0, 2, -1, 1'b1, 1'b0);                      // 0x80+0x80 lanes wrap to 0
        run(1, 1'b0, 2, -1, 1'b1, 1'b0);                      // random, ideal, WARMUP=0
        run(1, 1'b0, 2, 4, 1'b1, 1'b0);                       // lane 2 fault on 5th vector
        run(1, 1'b0, 2, int'($urandom_range(0, 15)), 1'b1, 1'b0);
        run(1, 1'b0, 3, -1, 1'b1, 1'b0);                      // 3-stage adder vs LATENCY=2
        run(1, 1'b1, 3, -1, 1'b1, 1'b0);
        run(1, 1'b0, 2, -1, 1'b1, 1'b1);                      // reset in 3rd DRIVE cycle
        run(1, 1'b0, 2, -1, 1'b0, 1'b0);                      // fresh run straight after
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vec_add_traffic_gen.md
Name: vec_add_traffic_gen

Overview:
- Drives and checks a 4-lane pipelined vector adder (a_0..a_3 + b_0..b_3 -> y_0..y_3, with en).
- After a warm-up delay that covers global-reset init, it drives NUM_VECS operand vectors, either pseudo-random or fixed.
- It predicts each sum, delays the prediction by the adder's pipeline latency, and compares it against the returned lanes.
- It reports done, pass and error/vector counts. Synthesizable, so the same block serves on-board and in simulation.

Parameters:
- WIDTH, 8: lane width in bits; constraint 4*WIDTH <= 32.
- LATENCY, 2: DUT cycles from en-sampled inputs to valid y; legal range 1..15.
- NUM_VECS, 16: vectors driven per run; legal range 1..65535.
- WARMUP, 4995: idle cycles after start before the first vector; 0 allowed.
- SEED_A, 32'h1: LFSR seed for the a lanes; 0 is replaced by 1.
- SEED_B, 32'h2: LFSR seed for the b lanes; 0 is replaced by 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low; clock clock
- start  in  1  level; sampled in IDLE only
- fixed_mode  in  1  sampled on leaving IDLE; 1 = constant vector
- a_0..a_3  out  WIDTH each  operand A lanes
- b_0..b_3  out  WIDTH each  operand B lanes
- en  out  1  DUT pipeline enable
- y_0..y_3  in  WIDTH each  DUT result lanes
- done  out  1  run complete; sticky
- pass  out  1  done and zero mismatches
- err_count  out  16  mismatched vectors; saturates at 16'hFFFF
- vec_count  out  16  vectors checked so far

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; all outputs 0; LFSRs reload seeds; expect pipe valids cleared. A reset mid-run aborts immediately with no partial report.
- FSM states: IDLE, WARMUP, DRIVE, DRAIN, DONE.
- IDLE -> WARMUP when start==1. fixed_mode is latched on this edge; the warm-up counter loads WARMUP.
- WARMUP: en=0, operands 0. Decrement each cycle; go to DRIVE on the cycle the counter is 0. With WARMUP=0, WARMUP lasts exactly 1 cycle.
- DRIVE: en=1 for exactly NUM_VECS consecutive cycles, one new vector per cycle, then DRAIN.
- DRAIN: en=1, operands 0, expect-pipe pushes with valid=0. Lasts LATENCY cycles, then DONE.
- DONE: en=0, operands 0, done=1, pass=(err_count==0). Held until reset; start is ignored.
- Operands are registered outputs. The vector presented in DRIVE cycle k is sampled by the DUT at the edge ending cycle k.
- Random mode:
  - a lane i = lfsr_a[WIDTH*i +: WIDTH]; b lane i = lfsr_b[WIDTH*i +: WIDTH].
  - Both LFSRs are 32-bit Galois, polynomial 32'h80200003, and advance once per DRIVE cycle only.
- Fixed mode: a = {0,3,2,1}, b = {-2,2,4,8} (lane 0 first), same every vector.
- Expected value per lane = (a+b) mod 2^WIDTH. Wrap is silent; no saturation.
- Expect pipe:
  - LATENCY-deep shift register of {valid, 4 lanes}, advancing only while en==1.
  - The entry pushed for DRIVE cycle k reaches the tail LATENCY cycles after the vector was presented. It is compared against y_0..y_3 sampled in that same cycle.
- Compare: at a valid tail, vec_count increments. err_count increments once if any lane differs (per vector, not per lane).
- Simultaneous events:
  - The last check lands in the final DRAIN cycle.
  - done asserts the cycle after, when counts are final.
  - pass is never 1 while done==0.
- en stays high through DRAIN so an en-gated DUT pipeline keeps advancing.

Decomposition:
- Shared package vec_add_tg_pkg:
  - state enum;
  - LANES=4;
  - LFSR polynomial constant;
  - fixed-vector constants;
  - lane array typedef logic [LANES-1:0][WIDTH-1:0], parameterized via a localparam.
- Sub-module: tg_lfsr32 (seed, advance, value), instantiated twice for a and b.
- Expect pipe and compare stay inline.

Test Plan:
- Fixed mode, ideal 2-register adder model, WARMUP=10, NUM_VECS=4:
  - y = {-2,5,6,9} from cycle WARMUP+1+2 onward;
  - done at cycle 18 after start; pass=1, err_count=0, vec_count=4.
- Random mode, NUM_VECS=16, ideal model:
  - first a = lfsr(SEED_A) slices, checked by the bench LFSR model;
  - pass=1, vec_count=16.
- Ideal model with lane 2 forced to +1 on the 5th vector only:
  - err_count=1, pass=0, vec_count=16.
- DUT model with 3 stages against LATENCY=2, random mode:
  - err_count=16, pass=0.
- Wrap, fixed-style override with a lane pair 8'h80+8'h80:
  - expected 8'h00; ideal model passes.
- reset=0 in the 3rd DRIVE cycle for 1 cycle, then start=1:
  - outputs 0 the cycle after reset; fresh run from seeds gives the same results as a clean run;
  - start held high through DONE causes no restart.
